// File: rtl/ob_cn_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : ob_cn_sched_if
//  Description : Bundle of the host FIFO head, conditional table and engine
//                issue handshakes seen by the issue scheduler.
//                slave  = scheduler view, master = surrounding logic view.
//  Revision    : 1.0  initial release
// ============================================================================
interface ob_cn_sched_if #(
  parameter int CMD_W = 64,
  parameter int UID_W = 16
);
  // Host command FIFO head
  logic             in_vld;
  logic [CMD_W-1:0] in_cmd;
  logic [1:0]       in_cls;
  logic [UID_W-1:0] in_uid;
  logic             in_pop;
  // Conditional (stop) table
  logic             cn_cmd_vld;
  logic             cn_full_r;
  logic             cn_mtr_vld_r;
  logic [CMD_W-1:0] cn_mtr_r;
  logic             cn_mtr_accept;
  logic             cn_cancel;
  logic [UID_W-1:0] cn_cancel_uid;
  logic             cn_cancel_hit_w;
  // Engine issue slot
  logic             eng_vld_r;
  logic [CMD_W-1:0] eng_cmd_r;
  logic             eng_src_r;
  logic             eng_accept;
  // Cancel-hit response
  logic             rsp_vld_r;
  logic [UID_W-1:0] rsp_uid_r;
  logic             rsp_accept;

  modport slave (
    input  in_vld, in_cmd, in_cls, in_uid,
    input  cn_full_r, cn_mtr_vld_r, cn_mtr_r, cn_cancel_hit_w,
    input  eng_accept, rsp_accept,
    output in_pop, cn_cmd_vld, cn_mtr_accept, cn_cancel, cn_cancel_uid,
    output eng_vld_r, eng_cmd_r, eng_src_r, rsp_vld_r, rsp_uid_r
  );

  modport master (
    output in_vld, in_cmd, in_cls, in_uid,
    output cn_full_r, cn_mtr_vld_r, cn_mtr_r, cn_cancel_hit_w,
    output eng_accept, rsp_accept,
    input  in_pop, cn_cmd_vld, cn_mtr_accept, cn_cancel, cn_cancel_uid,
    input  eng_vld_r, eng_cmd_r, eng_src_r, rsp_vld_r, rsp_uid_r
  );
endinterface
`default_nettype wire

// File: rtl/ob_cn_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ob_cn_sched
//  Description : Issue scheduler between the host command FIFO head, the
//                conditional table and the book engine. Conditional commands
//                go to the table, cancels are looked up in the table first,
//                and host / matured commands share one registered engine
//                slot with a starvation-bounded matured priority.
//  Revision    : 1.0  initial release
// ============================================================================
module ob_cn_sched #(
  parameter int MAX_CONSEC = 4,
  parameter int CNT_W      = $clog2(MAX_CONSEC + 1)
) (
  input  wire            clk,
  input  wire            rst,
  ob_cn_sched_if.slave   bus
);

  localparam logic [1:0]       CLS_COND   = 2'd1;
  localparam logic [1:0]       CLS_CANCEL = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CONSEC);

  logic [CNT_W-1:0] starve_cnt;

  logic is_cond;
  logic is_cancel;
  logic is_normal;
  logic eng_free;
  logic rsp_free;
  logic hv;
  logic host_win;
  logic mtr_win;
  logic cond_take;

  // Arbitration between host head and matured entry; reset masks every strobe
  always_comb begin
    is_cond   = (bus.in_cls == CLS_COND);
    is_cancel = (bus.in_cls == CLS_CANCEL);
    // Reserved class 3 falls through to NORMAL handling
    is_normal = ~is_cond & ~is_cancel;
    eng_free  = ~bus.eng_vld_r | bus.eng_accept;
    rsp_free  = ~bus.rsp_vld_r | bus.rsp_accept;
    hv        = ~rst & bus.in_vld &
                ((is_normal & eng_free) | (is_cancel & eng_free & rsp_free));
    host_win  = hv & (~bus.cn_mtr_vld_r | (starve_cnt == CNT_MAX));
    // host_win excludes mtr_win, so a cancel lookup never overlaps a matured take
    mtr_win   = ~rst & bus.cn_mtr_vld_r & eng_free & ~host_win;
    cond_take = ~rst & bus.in_vld & is_cond & ~bus.cn_full_r;

    bus.in_pop        = host_win | cond_take;
    bus.cn_cmd_vld    = cond_take;
    bus.cn_mtr_accept = mtr_win;
    bus.cn_cancel     = host_win & is_cancel;
    bus.cn_cancel_uid = rst ? '0 : bus.in_uid;
  end

  // Engine slot, response slot and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.eng_vld_r <= 1'b0;
      bus.eng_cmd_r <= '0;
      bus.eng_src_r <= 1'b0;
      bus.rsp_vld_r <= 1'b0;
      bus.rsp_uid_r <= '0;
      starve_cnt    <= '0;
    end else begin
      if (bus.eng_accept) begin
        bus.eng_vld_r <= 1'b0;
      end
      if (bus.rsp_accept) begin
        bus.rsp_vld_r <= 1'b0;
      end

      if (mtr_win) begin
        bus.eng_vld_r <= 1'b1;
        bus.eng_cmd_r <= bus.cn_mtr_r;
        bus.eng_src_r <= 1'b1;
        // Count only matured issues that actually made a host head wait
        if (hv) begin
          starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + CNT_W'(1);
        end else begin
          starve_cnt <= '0;
        end
      end else if (host_win) begin
        starve_cnt <= '0;
        if (is_cancel & bus.cn_cancel_hit_w) begin
          // Cancelled inside the table: answer locally, engine untouched
          bus.rsp_vld_r <= 1'b1;
          bus.rsp_uid_r <= bus.in_uid;
        end else begin
          bus.eng_vld_r <= 1'b1;
          bus.eng_cmd_r <= bus.in_cmd;
          bus.eng_src_r <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ob_cn_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ob_cn_sched
//  Description : Self-checking bench for ob_cn_sched: directed scenarios plus
//                randomized traffic against a cycle-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ob_cn_sched;

  localparam int MAX_CONSEC = 4;
  localparam int CMD_W      = 16;
  localparam int UID_W      = 8;

  logic clk;
  logic rst;

  ob_cn_sched_if #(.CMD_W(CMD_W), .UID_W(UID_W)) bus ();

  ob_cn_sched #(.MAX_CONSEC(MAX_CONSEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  bit             m_eng_vld;
  bit [CMD_W-1:0] m_eng_cmd;
  bit             m_eng_src;
  bit             m_rsp_vld;
  bit [UID_W-1:0] m_rsp_uid;
  int             m_starve;

  // Last observed strobes, for directed checks
  logic last_pop, last_alloc, last_macc, last_cancel;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check strobes against the model, clock, check slots.
  task automatic cyc(input bit r, input bit vld, input bit [1:0] cls,
                     input bit [CMD_W-1:0] cmd, input bit [UID_W-1:0] uid,
                     input bit full, input bit mvld, input bit [CMD_W-1:0] mcmd,
                     input bit hit, input bit eacc, input bit racc);
    bit normal, cancel, cond, eng_free, rsp_free, host_ready, host_turn, mtr_turn, cond_alloc;
    bit e_pop, e_alloc, e_macc, e_cancel;
    bit [UID_W-1:0] e_uid;
    bit             n_eng_vld, n_eng_src, n_rsp_vld;
    bit [CMD_W-1:0] n_eng_cmd;
    bit [UID_W-1:0] n_rsp_uid;
    int             n_starve;

    rst                 = r;
    bus.in_vld          = vld;
    bus.in_cls          = cls;
    bus.in_cmd          = cmd;
    bus.in_uid          = uid;
    bus.cn_full_r       = full;
    bus.cn_mtr_vld_r    = mvld;
    bus.cn_mtr_r        = mcmd;
    bus.cn_cancel_hit_w = hit;
    bus.eng_accept      = eacc;
    bus.rsp_accept      = racc;
    #2;

    cond   = (cls == 2'd1);
    cancel = (cls == 2'd2);
    normal = !cond && !cancel;

    n_eng_vld = m_eng_vld && !eacc;
    n_eng_cmd = m_eng_cmd;
    n_eng_src = m_eng_src;
    n_rsp_vld = m_rsp_vld && !racc;
    n_rsp_uid = m_rsp_uid;
    n_starve  = m_starve;

    if (r) begin
      {e_pop, e_alloc, e_macc, e_cancel} = '0;
      e_uid = '0;
      n_eng_vld = 0; n_eng_cmd = '0; n_eng_src = 0;
      n_rsp_vld = 0; n_rsp_uid = '0; n_starve = 0;
    end else begin
      eng_free   = !m_eng_vld || eacc;
      rsp_free   = !m_rsp_vld || racc;
      if (!vld)        host_ready = 0;
      else if (normal) host_ready = eng_free;
      else if (cancel) host_ready = eng_free && rsp_free;
      else             host_ready = 0;
      host_turn  = host_ready && (!mvld || m_starve == MAX_CONSEC);
      mtr_turn   = mvld && eng_free && !host_turn;
      cond_alloc = vld && cond && !full;

      e_pop    = host_turn || cond_alloc;
      e_alloc  = cond_alloc;
      e_macc   = mtr_turn;
      e_cancel = host_turn && cancel;
      e_uid    = uid;

      if (mtr_turn) begin
        n_eng_vld = 1; n_eng_cmd = mcmd; n_eng_src = 1;
        n_starve  = host_ready ? ((m_starve + 1 > MAX_CONSEC) ? MAX_CONSEC : m_starve + 1) : 0;
      end else if (host_turn) begin
        n_starve = 0;
        if (cancel && hit) begin
          n_rsp_vld = 1; n_rsp_uid = uid;
        end else begin
          n_eng_vld = 1; n_eng_cmd = cmd; n_eng_src = 0;
        end
      end
    end

    last_pop    = bus.in_pop;
    last_alloc  = bus.cn_cmd_vld;
    last_macc   = bus.cn_mtr_accept;
    last_cancel = bus.cn_cancel;
    chk("in_pop",        bus.in_pop,        e_pop);
    chk("cn_cmd_vld",    bus.cn_cmd_vld,    e_alloc);
    chk("cn_mtr_accept", bus.cn_mtr_accept, e_macc);
    chk("cn_cancel",     bus.cn_cancel,     e_cancel);
    chk("cn_cancel_uid", bus.cn_cancel_uid, e_uid);

    @(posedge clk);
    #1;
    m_eng_vld = n_eng_vld; m_eng_cmd = n_eng_cmd; m_eng_src = n_eng_src;
    m_rsp_vld = n_rsp_vld; m_rsp_uid = n_rsp_uid; m_starve  = n_starve;
    chk("eng_vld_r", bus.eng_vld_r, m_eng_vld);
    chk("eng_cmd_r", bus.eng_cmd_r, m_eng_cmd);
    chk("eng_src_r", bus.eng_src_r, m_eng_src);
    chk("rsp_vld_r", bus.rsp_vld_r, m_rsp_vld);
    chk("rsp_uid_r", bus.rsp_uid_r, m_rsp_uid);
  endtask

  initial begin
    logic [CMD_W-1:0] held;
    rst = 1'b1;
    bus.in_vld = 0; bus.in_cls = 0; bus.in_cmd = '0; bus.in_uid = '0;
    bus.cn_full_r = 0; bus.cn_mtr_vld_r = 0; bus.cn_mtr_r = '0; bus.cn_cancel_hit_w = 0;
    bus.eng_accept = 0; bus.rsp_accept = 0;
    m_eng_vld = 0; m_eng_cmd = '0; m_eng_src = 0; m_rsp_vld = 0; m_rsp_uid = '0; m_starve = 0;
    @(posedge clk); #1;

    // Reset state with every input active
    cyc(1, 1, 2'd2, 16'h1111, 8'h11, 0, 1, 16'h2222, 1, 1, 1);
    chk("rst_eng_vld", bus.eng_vld_r, 0);

    // 1: single NORMAL issue
    cyc(0, 1, 2'd0, 16'hA001, 8'h00, 0, 0, 16'h0, 0, 1, 0);
    chk("t1_pop", last_pop, 1);
    chk("t1_vld", bus.eng_vld_r, 1);
    chk("t1_src", bus.eng_src_r, 0);
    cyc(0, 0, 2'd0, 16'h0, 8'h00, 0, 0, 16'h0, 0, 1, 0);
    chk("t1_pop_once", last_pop, 0);

    // 2: matured stream vs waiting host, 4 matured then 1 host, repeating
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 2'd0, 16'hB000 + 16'(i), 8'h00, 0, 1, 16'hC000 + 16'(i), 0, 1, 0);
      chk("t2_src", bus.eng_src_r, (i % 5 == 4) ? 1'b0 : 1'b1);
    end

    // 5: starvation counter at max, CANCEL miss beats matured
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 2'd0, 16'hB100, 8'h00, 0, 1, 16'hC100 + 16'(i), 0, 1, 0);
    cyc(0, 1, 2'd2, 16'hD0D0, 8'h55, 0, 1, 16'hC1FF, 0, 1, 0);
    chk("t5_cancel", last_cancel, 1);
    chk("t5_macc", last_macc, 0);
    chk("t5_src", bus.eng_src_r, 0);
    chk("t5_cmd", bus.eng_cmd_r, 16'hD0D0);

    // 3: COND head blocked by full table while matured issue continues
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 2'd1, 16'hE000, 8'h00, 1, 1, 16'hC200 + 16'(i), 0, 1, 0);
      chk("t3_nopop", last_pop, 0);
      chk("t3_macc", last_macc, 1);
    end
    cyc(0, 1, 2'd1, 16'hE000, 8'h00, 0, 1, 16'hC210, 0, 1, 0);
    chk("t3_alloc", last_alloc, 1);
    chk("t3_pop", last_pop, 1);

    // 4: CANCEL hit answered locally, second CANCEL stalls on the full response slot
    cyc(0, 0, 2'd0, 16'h0, 8'h00, 0, 0, 16'h0, 0, 1, 0);
    cyc(0, 1, 2'd2, 16'hF000, 8'h2A, 0, 0, 16'h0, 1, 1, 0);
    chk("t4_rsp_vld", bus.rsp_vld_r, 1);
    chk("t4_rsp_uid", bus.rsp_uid_r, 8'h2A);
    chk("t4_eng_vld", bus.eng_vld_r, 0);
    cyc(0, 1, 2'd2, 16'hF001, 8'h2B, 0, 0, 16'h0, 1, 1, 0);
    chk("t4_stall", last_pop, 0);
    cyc(0, 1, 2'd2, 16'hF001, 8'h2B, 0, 0, 16'h0, 1, 1, 1);
    chk("t4_release", last_pop, 1);
    chk("t4_rsp_uid2", bus.rsp_uid_r, 8'h2B);

    // 6: engine backpressure, then reset mid-stall
    cyc(0, 1, 2'd0, 16'h6000, 8'h00, 0, 0, 16'h0, 0, 1, 1);
    held = bus.eng_cmd_r;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 2'd0, 16'h6100, 8'h00, 0, 1, 16'h6200, 0, 0, 1);
      chk("t6_hold", bus.eng_cmd_r, held);
      chk("t6_nopop", last_pop, 0);
      chk("t6_nomacc", last_macc, 0);
    end
    cyc(1, 1, 2'd0, 16'h6100, 8'h00, 0, 1, 16'h6200, 0, 0, 1);
    chk("t6_rst_vld", bus.eng_vld_r, 0);
    chk("t6_rst_pop", last_pop, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 75),
          2'($urandom_range(0, 3)),
          CMD_W'($urandom), UID_W'($urandom),
          ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 55),
          CMD_W'($urandom),
          ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 50));
      chk("excl_cancel_macc", last_cancel & last_macc, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
